// File: rtl/divisor_8bits_seq.sv
// -----------------------------------------------------------------------------
// divisor_8bits_seq
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A start with a non-zero divisor finishes LARGURA cycles later. A start with a
// zero divisor finishes on the start edge and raises erro_div_zero.
// Optional feature: define DIVISOR_COM_SINAL_EN for two's-complement operands.
// The magnitudes are divided, and the signs are fixed up on the edge that
// enters FIM.
// -----------------------------------------------------------------------------
module divisor_8bits_seq #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto,
  output logic               ocupado,
  output logic               pronto,
  output logic               erro_div_zero
);

  localparam int CNT_W = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(LARGURA - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] dvd_q, dvd_d;        // dividend, shifted out MSB first
  logic [LARGURA-1:0] dvs_q, dvs_d;        // latched divisor (magnitude)
  logic [LARGURA:0]   rem_q, rem_d;        // partial remainder, one guard bit
  logic [LARGURA-1:0] quo_q, quo_d;        // quotient bits collected so far
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // iteration counter
  logic [LARGURA-1:0] quociente_q, quociente_d;
  logic [LARGURA-1:0] resto_q, resto_d;
  logic               erro_q, erro_d;

`ifdef DIVISOR_COM_SINAL_EN
  logic               neg_quo_q, neg_quo_d;  // quotient must be negated
  logic               neg_rem_q, neg_rem_d;  // remainder must be negated
  logic [LARGURA-1:0] mag_dvd, mag_dvs;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract, and
  // keep the difference only when no borrow occurs.
  logic [LARGURA+1:0] desloc;
  logic [LARGURA+1:0] dif;
  logic               borrow;
  logic [LARGURA:0]   rem_step;
  logic [LARGURA-1:0] quo_step;

  // Datapath for a single division step
  always_comb begin
    desloc   = {rem_q, dvd_q[LARGURA-1]};
    dif      = desloc - {2'b00, dvs_q};
    borrow   = dif[LARGURA+1];
    rem_step = borrow ? desloc[LARGURA:0] : dif[LARGURA:0];
    quo_step = {quo_q[LARGURA-2:0], ~borrow};
  end

  // Next-state and datapath control for the OCIOSO/CALCULA/FIM FSM
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so a path that
    // skips an assignment holds the register value and does not infer a latch.
    estado_d    = estado_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quociente_d = quociente_q;
    resto_d     = resto_q;
    erro_d      = erro_q;
`ifdef DIVISOR_COM_SINAL_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    mag_dvd     = dividendo[LARGURA-1] ? ('0 - dividendo) : dividendo;
    mag_dvs     = divisor[LARGURA-1]   ? ('0 - divisor)   : divisor;
`endif

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          if (divisor == '0) begin
            // A zero divisor is resolved on the start edge.
            quociente_d = '1;
            resto_d     = dividendo;
            erro_d      = 1'b1;
            estado_d    = FIM;
          end else begin
`ifdef DIVISOR_COM_SINAL_EN
            dvd_d     = mag_dvd;
            dvs_d     = mag_dvs;
            neg_quo_d = dividendo[LARGURA-1] ^ divisor[LARGURA-1];
            neg_rem_d = dividendo[LARGURA-1];
`else
            dvd_d     = dividendo;
            dvs_d     = divisor;
`endif
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = '0;
            estado_d  = CALCULA;
          end
        end
      end

      CALCULA: begin
        dvd_d = {dvd_q[LARGURA-2:0], 1'b0};
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == ULTIMO) begin
          // The last step writes the results directly, so the latency is
          // the same in both the unsigned and the signed builds.
`ifdef DIVISOR_COM_SINAL_EN
          quociente_d = neg_quo_q ? ('0 - quo_step) : quo_step;
          resto_d     = neg_rem_q ? ('0 - rem_step[LARGURA-1:0])
                                  : rem_step[LARGURA-1:0];
`else
          quociente_d = quo_step;
          resto_d     = rem_step[LARGURA-1:0];
`endif
          erro_d   = 1'b0;
          estado_d = FIM;
        end
      end

      FIM: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers, with a synchronous reset that wins over everything
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (reset) begin
      estado_q    <= OCIOSO;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quociente_q <= '0;
      resto_q     <= '0;
      erro_q      <= 1'b0;
`ifdef DIVISOR_COM_SINAL_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quociente_q <= quociente_d;
      resto_q     <= resto_d;
      erro_q      <= erro_d;
`ifdef DIVISOR_COM_SINAL_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign quociente     = quociente_q;
  assign resto         = resto_q;
  assign erro_div_zero = erro_q;
  assign ocupado       = (estado_q != OCIOSO);
  assign pronto        = (estado_q == FIM);

endmodule

// File: tb/tb_divisor_8bits_seq.sv
// -----------------------------------------------------------------------------
// tb_divisor_8bits_seq
// Table-driven vectors, hand-written multi-cycle sequences, and randomized
// operations checked against an arithmetic reference model.
// Build with DIVISOR_COM_SINAL_EN defined to also exercise signed operation.
// -----------------------------------------------------------------------------
module tb_divisor_8bits_seq;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [7:0] dividendo;
  logic [7:0] divisor;
  logic [7:0] quociente;
  logic [7:0] resto;
  logic       ocupado;
  logic       pronto;
  logic       erro_div_zero;

  int total = 0;
  int bad   = 0;

  divisor_8bits_seq #(.LARGURA(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .dividendo    (dividendo),
    .divisor      (divisor),
    .quociente    (quociente),
    .resto        (resto),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .erro_div_zero(erro_div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model built from plain arithmetic.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic e, output int lat);
    int sa, sb;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; e = 1'b1; lat = 0;
    end else begin
`ifdef DIVISOR_COM_SINAL_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = 8'(sa / sb);
      r = 8'(sa % sb);
      e = 1'b0;
      lat = 8;
    end
  endtask

  // Pulse iniciar for one edge, scramble the operands, then wait (bounded)
  // for pronto. lat counts the edges after the start edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    dividendo = a;
    divisor   = b;
    iniciar   = 1'b1;
    tick();
    iniciar   = 1'b0;
    dividendo = 8'($urandom);
    divisor   = 8'($urandom);
    lat = 0;
    while (!pronto && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input logic e,
                       input int lat);
    int n;
    run_op(a, b, n);
    check({tag, " pronto"}, 32'(pronto), 32'd1);
    check({tag, " latency"}, n, lat);
    check({tag, " quociente"}, 32'(quociente), 32'(q));
    check({tag, " resto"}, 32'(resto), 32'(r));
    check({tag, " erro"}, 32'(erro_div_zero), 32'(e));
    check({tag, " ocupado@pronto"}, 32'(ocupado), 32'd1);
    tick();
    check({tag, " pronto one cycle"}, 32'(pronto), 32'd0);
    check({tag, " ocupado drop"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    int n;
    int extra;
    logic [7:0] a, b, mq, mr;
    logic me;
    int ml;

    reset = 1'b1; iniciar = 1'b0; dividendo = 8'd0; divisor = 8'd0;

    // Positive operands and a zero divisor give the same results in both builds.
    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 8});
    vecs.push_back('{8'd5,   8'd0,   8'd255, 8'd5,  1'b1, 0});
    vecs.push_back('{8'd20,  8'd6,   8'd3,   8'd2,  1'b0, 8});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 8});
    vecs.push_back('{8'd127, 8'd127, 8'd1,   8'd0,  1'b0, 8});
    vecs.push_back('{8'd126, 8'd127, 8'd0,   8'd126,1'b0, 8});
    vecs.push_back('{8'd99,  8'd3,   8'd33,  8'd0,  1'b0, 8});
    vecs.push_back('{8'd0,   8'd0,   8'd255, 8'd0,  1'b1, 0});
`ifdef DIVISOR_COM_SINAL_EN
    vecs.push_back('{8'hF9,  8'd2,   8'hFD,  8'hFF, 1'b0, 8});
    vecs.push_back('{8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, 8});
    vecs.push_back('{8'hEC,  8'h06,  8'hFD,  8'hFE, 1'b0, 8});
    vecs.push_back('{8'h80,  8'h00,  8'hFF,  8'h80, 1'b1, 0});
`else
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254,1'b0, 8});
    vecs.push_back('{8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 8});
`endif

    // Reset state
    tick(); tick();
    check("reset quociente", 32'(quociente), 32'd0);
    check("reset resto", 32'(resto), 32'd0);
    check("reset ocupado", 32'(ocupado), 32'd0);
    check("reset pronto", 32'(pronto), 32'd0);
    check("reset erro", 32'(erro_div_zero), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
            vecs[i].e, vecs[i].lat);

    // 255/1, then 3/200 requested from the pronto cycle on; it may only start
    // on the first edge spent in OCIOSO.
    run_op(8'd255, 8'd1, n);
    check("b2b first pronto", 32'(pronto), 32'd1);
    check("b2b first latency", n, 8);
    check("b2b first quociente", 32'(quociente), 32'd255);
    check("b2b first resto", 32'(resto), 32'd0);
    dividendo = 8'd3; divisor = 8'd200; iniciar = 1'b1;
    tick();   // FIM -> OCIOSO, request ignored
    check("b2b ocupado drop", 32'(ocupado), 32'd0);
    check("b2b pronto drop", 32'(pronto), 32'd0);
    tick();   // accepted in OCIOSO
    iniciar = 1'b0; dividendo = 8'($urandom); divisor = 8'($urandom);
    check("b2b second accepted", 32'(ocupado), 32'd1);
    tick(); tick(); tick();
    check("b2b hold quociente", 32'(quociente), 32'd255);
    n = 3;
    while (!pronto && n < 20) begin tick(); n++; end
    check("b2b second pronto", 32'(pronto), 32'd1);
    check("b2b second latency", n, 8);
    check("b2b second quociente", 32'(quociente), 32'd0);
    check("b2b second resto", 32'(resto), 32'd3);
    tick();
    check("b2b second ocupado drop", 32'(ocupado), 32'd0);

    // iniciar with 9/2 at edge k+3 during 100/7 is ignored
    dividendo = 8'd100; divisor = 8'd7; iniciar = 1'b1;
    tick();   // edge k
    iniciar = 1'b0;
    tick(); tick();   // k+1, k+2
    dividendo = 8'd9; divisor = 8'd2; iniciar = 1'b1;
    tick();   // k+3
    iniciar = 1'b0;
    n = 3;
    while (!pronto && n < 20) begin tick(); n++; end
    check("ignore latency", n, 8);
    check("ignore quociente", 32'(quociente), 32'd14);
    check("ignore resto", 32'(resto), 32'd2);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pronto) extra++;
    end
    check("ignore no second pronto", extra, 0);
    check("ignore result held", 32'(quociente), 32'd14);

    // Reset at edge k+4 during 100/7, then 20/6 right after
    dividendo = 8'd100; divisor = 8'd7; iniciar = 1'b1;
    tick();   // k
    iniciar = 1'b0;
    tick(); tick(); tick();   // k+1..k+3
    reset = 1'b1;
    tick();   // k+4
    reset = 1'b0;
    check("abort quociente", 32'(quociente), 32'd0);
    check("abort resto", 32'(resto), 32'd0);
    check("abort ocupado", 32'(ocupado), 32'd0);
    check("abort pronto", 32'(pronto), 32'd0);
    check("abort erro", 32'(erro_div_zero), 32'd0);
    do_op("after reset", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 8);

    // Reset on the edge that would enter FIM: no pronto follows
    dividendo = 8'd100; divisor = 8'd7; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();   // k+8 with reset
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (pronto) extra++;
      tick();
    end
    check("reset@fim no pronto", extra, 0);
    check("reset@fim quociente", 32'(quociente), 32'd0);

    // Reset while in FIM clears the strobe
    run_op(8'd50, 8'd0, n);
    check("div0 pronto", 32'(pronto), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset in fim pronto", 32'(pronto), 32'd0);
    check("reset in fim erro", 32'(erro_div_zero), 32'd0);
    check("reset in fim resto", 32'(resto), 32'd0);
    tick();

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (i < 4) b = 8'($urandom_range(1, 3));
      model(a, b, mq, mr, me, ml);
      do_op($sformatf("rand%0d %0h/%0h", i, a, b), a, b, mq, mr, me, ml);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
